result_writer: RTL and testbench
================================

RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 SHALL have parameter N_ROWS, default `N_ROWS; matrix row count.
REQ-002 SHALL have parameter N_COLUMNS, default `N_COLUMNS; matrix column count.
REQ-003 SHALL have parameter WIDTH, default `WIDTH; element width in bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH_RAM; RAM address width.
REQ-005 SHALL have parameter BASE_ADDR, default 0; RAM address of element [0][0].
REQ-006 SHALL have port clk  input  1  system clock; single clock domain, all state on posedge clk.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  request to write the present matrix to RAM.
REQ-009 SHALL have port hold  input  1  RAM-side stall; pauses the write stream while high.
REQ-010 SHALL have port in  input  [N_ROWS-1:0][N_COLUMNS-1:0][WIDTH-1:0]  matrix to serialize.
REQ-011 SHALL have port addr  output  ADDR_WIDTH  RAM write address.
REQ-012 SHALL have port data_in  output  WIDTH  RAM write data.
REQ-013 SHALL have port write_enable  output  1  RAM write strobe.
REQ-014 SHALL have port busy  output  1  high from first write cycle through last write.
REQ-015 SHALL have port done  output  1  one-cycle pulse after final element written.

Function
REQ-016 SHALL implement FSM with states IDLE, WRITE, DONE; all outputs registered.
REQ-017 In IDLE, start=1 at a clock edge SHALL snapshot in into an internal buffer, clear element index to 0, and enter WRITE.
REQ-018 Changes on in after the snapshot edge SHALL NOT affect written data until the next accepted start.
REQ-019 In WRITE with hold=0, each cycle SHALL present write_enable=1, data_in=buffer[i/N_COLUMNS][i%N_COLUMNS], addr=(BASE_ADDR+i) mod 2^ADDR_WIDTH, then increment i.
REQ-020 Order SHALL be row-major: [0][0], [0][1], ..., [0][N_COLUMNS-1], [1][0], ..., [N_ROWS-1][N_COLUMNS-1].
REQ-021 In WRITE with hold=1 at the edge, write_enable SHALL be 0 next cycle, i SHALL not advance, addr/data_in SHALL hold their values.
REQ-022 First write_enable SHALL be asserted in the cycle after the start edge (latency 1), given hold=0.
REQ-023 Exactly N_ROWS*N_COLUMNS write_enable cycles SHALL occur per accepted start; with hold always 0 they are contiguous.
REQ-024 After the write of element N_ROWS*N_COLUMNS-1, FSM SHALL enter DONE: write_enable=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-025 start SHALL be ignored in WRITE and DONE; no queuing.
REQ-026 busy SHALL equal 1 exactly while in WRITE, including hold cycles.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH without error indication.
REQ-028 Element index counter SHALL be sized ceil(log2(N_ROWS*N_COLUMNS+1)) bits minimum.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force IDLE, addr=0, data_in=0, write_enable=0, busy=0, done=0, index=0, buffer=0.
REQ-030 Reset asserted mid-WRITE SHALL abort the transfer; no further writes and no done pulse after release until a new start.
REQ-031 First start SHALL be accepted only at a clock edge with rst=1.

Verification
REQ-032 N_ROWS=N_COLUMNS=3, WIDTH=8, BASE_ADDR=0, in[r][c]=16*r+c, start pulse, hold=0 -> 9 consecutive writes addr 0..8, data 00,01,02,10,11,12,20,21,22; done one cycle after last write.
REQ-033 Same stimulus with hold=1 for 2 cycles after third write -> write_enable low 2 cycles, addr stays 2 then resumes 3; busy stays 1; total 9 writes.
REQ-034 BASE_ADDR=254, ADDR_WIDTH=8 -> addresses 254,255,0,1,...,6.
REQ-035 in changed to all FF and start re-pulsed during WRITE -> original data written, no second transfer, single done pulse.
REQ-036 rst=0 after fourth write -> all outputs 0 immediately; after release no writes, no done until next start.
REQ-037 start held high continuously -> back-to-back transfers separated by DONE and IDLE cycles, each 9 writes with its own done pulse.

Source files
------------

// File: rtl/result_writer.sv
// Serializes a snapshot of a matrix into RAM writes, one element per cycle in row-major order.
// The write stream can be stalled from the RAM side; a done pulse marks the end of each transfer.
`ifndef N_ROWS
`define N_ROWS 3
`endif
`ifndef N_COLUMNS
`define N_COLUMNS 3
`endif
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH_RAM
`define ADDR_WIDTH_RAM 8
`endif

module result_writer #(
  parameter int unsigned N_ROWS     = `N_ROWS,
  parameter int unsigned N_COLUMNS  = `N_COLUMNS,
  parameter int unsigned WIDTH      = `WIDTH,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH_RAM,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic                                           hold,
  input  logic [N_ROWS-1:0][N_COLUMNS-1:0][WIDTH-1:0]    in,
  output logic [ADDR_WIDTH-1:0]                          addr,
  output logic [WIDTH-1:0]                               data_in,
  output logic                                           write_enable,
  output logic                                           busy,
  output logic                                           done
);

  localparam int unsigned Total = N_ROWS * N_COLUMNS;
  localparam int unsigned IdxW  = $clog2(Total + 1);
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  // Flattened snapshot: element i sits at row i/N_COLUMNS, column i%N_COLUMNS.
  logic [Total-1:0][WIDTH-1:0]  buf_q, buf_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [WIDTH-1:0]             data_q, data_d;
  logic                         we_q, we_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          buf_d   = in;
          state_d = StWrite;
          busy_d  = 1'b1;
          idx_d   = '0;
          // Element 0 goes out straight from the input so the first write has latency 1.
          if (!hold) begin
            we_d   = 1'b1;
            addr_d = BaseAddr;
            data_d = in[0][0];
            idx_d  = IdxW'(1);
          end
        end
      end
      StWrite: begin
        if (idx_q == IdxW'(Total)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!hold) begin
          we_d   = 1'b1;
          addr_d = BaseAddr + ADDR_WIDTH'(idx_q);
          data_d = buf_q[idx_q];
          idx_d  = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr         = addr_q;
  assign data_in      = data_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: two instances (base 0 and base 254) share all inputs.
module tb_result_writer;

  localparam int R  = 3;
  localparam int C  = 3;
  localparam int W  = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst, start, hold;
  logic [R-1:0][C-1:0][W-1:0] mat;
  logic [R-1:0][C-1:0][W-1:0] snap;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  data_a, data_b;
  logic we_a, we_b, busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  result_writer #(.N_ROWS(R), .N_COLUMNS(C), .WIDTH(W), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .in(mat),
    .addr(addr_a), .data_in(data_a), .write_enable(we_a), .busy(busy_a), .done(done_a)
  );

  result_writer #(.N_ROWS(R), .N_COLUMNS(C), .WIDTH(W), .ADDR_WIDTH(AW), .BASE_ADDR(254)) dut_b (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .in(mat),
    .addr(addr_b), .data_in(data_b), .write_enable(we_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags();
    return {we_a, busy_a, done_a, we_b, busy_b, done_b};
  endfunction

  function automatic logic [5:0] dup(input logic [2:0] f);
    return {f, f};
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'(16 * (i / C) + (i % C));
  endfunction

  task automatic load_pattern();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mat[r][c] = 8'(16 * r + c);
  endtask

  typedef struct {
    logic       we, busy, done, chk_ad;
    logic [7:0] addr_a, addr_b, data;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n_w, n_d, bad, prev_hold, finished;
    logic [7:0] last_a, last_b, last_d;

    // Expected outputs in the cycles following one start edge, pattern 16*r+c, hold low.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd254, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd255, 8'h01};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0,   8'h02};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd1,   8'h10};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd4, 8'd2,   8'h11};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 8'd3,   8'h12};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd6, 8'd4,   8'h20};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 8'd5,   8'h21};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd8, 8'd6,   8'h22};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0,   8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   8'h00};

    // Reset: asynchronous, and start during reset is not accepted.
    rst = 1'b0; start = 1'b0; hold = 1'b0; mat = '0;
    #1;
    chk("reset_async", 64'({addr_a, data_a, flags(), addr_b, data_b}), 64'd0);
    start = 1'b1;
    tick();
    chk("reset_start_ignored", 64'({addr_a, data_a, flags(), addr_b, data_b}), 64'd0);
    start = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_after_release", 64'(flags()), 64'd0);

    // Basic transfer from the vector table (also covers address wrap on dut_b).
    load_pattern();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("tbl%0d_flags", k), 64'(flags()),
          64'(dup({tbl[k].we, tbl[k].busy, tbl[k].done})));
      if (tbl[k].chk_ad)
        chk($sformatf("tbl%0d_addr_data", k), 64'({addr_a, addr_b, data_a, data_b}),
            64'({tbl[k].addr_a, tbl[k].addr_b, tbl[k].data, tbl[k].data}));
      tick();
    end

    // Hold for two cycles after the third write.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("hold_third_write", 64'({we_a, addr_a, data_a}), 64'({1'b1, 8'd2, 8'h02}));
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("hold_cycle%0d", k), 64'({flags(), addr_a, data_a, addr_b}),
          64'({dup(3'b010), 8'd2, 8'h02, 8'd0}));
    end
    hold = 1'b0;
    tick();
    chk("hold_resume", 64'({flags(), addr_a, data_a}), 64'({dup(3'b110), 8'd3, 8'h10}));
    n_w = 4; n_d = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_w += int'(we_a);
      n_d += int'(done_a);
    end
    chk("hold_total_writes", 64'(n_w), 64'd9);
    chk("hold_done_count", 64'(n_d), 64'd1);

    // Snapshot and start ignored mid-transfer.
    start = 1'b1;
    tick();
    start = 1'b0;
    n_w = 0; n_d = 0; bad = 0;
    for (int k = 0; k < 25; k++) begin
      if (we_a) begin
        if (data_a !== pat(n_w)) bad++;
        n_w++;
      end
      n_d += int'(done_a);
      if (k == 1) begin
        mat = '1;
        start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      tick();
    end
    chk("snapshot_data_errors", 64'(bad), 64'd0);
    chk("snapshot_single_transfer", 64'({n_w[7:0], n_d[7:0]}), 64'({8'd9, 8'd1}));

    // Reset after the fourth write aborts the transfer.
    load_pattern();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort_fourth_write", 64'({we_a, addr_a}), 64'({1'b1, 8'd3}));
    #1 rst = 1'b0;
    #1;
    chk("abort_async_clear", 64'({addr_a, data_a, flags(), addr_b, data_b}), 64'd0);
    tick();
    rst = 1'b1;
    n_w = 0; n_d = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_w += int'(we_a | we_b);
      n_d += int'(done_a | done_b);
    end
    chk("abort_no_activity", 64'({n_w[7:0], n_d[7:0]}), 64'd0);

    // start held high: 9 writes, done, idle, repeat (period 11).
    start = 1'b1;
    tick();
    for (int c = 0; c < 33; c++) begin
      int m;
      m = c % 11;
      if (m < 9) begin
        chk($sformatf("bb%0d", c), 64'({flags(), addr_a, data_a}),
            64'({dup(3'b110), 8'(m), pat(m)}));
      end else if (m == 9) begin
        chk($sformatf("bb%0d_done", c), 64'(flags()), 64'(dup(3'b001)));
      end else begin
        chk($sformatf("bb%0d_idle", c), 64'(flags()), 64'd0);
      end
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("bb_drained", 64'(flags()), 64'd0);

    // Randomized transfers with random stalls against a transaction-level model.
    for (int t = 0; t < 20; t++) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) mat[r][c] = 8'($urandom);
      snap = mat;
      start = 1'b1; hold = 1'b0;
      tick();
      start = 1'b0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) mat[r][c] = 8'($urandom);
      n_w = 0; prev_hold = 0; finished = 0;
      last_a = '0; last_b = '0; last_d = '0;
      for (int cyc = 0; cyc < 100 && finished == 0; cyc++) begin
        if (n_w < 9 && prev_hold == 0) begin
          last_a = 8'(n_w);
          last_b = 8'((254 + n_w) % 256);
          last_d = snap[n_w / C][n_w % C];
          chk($sformatf("rand%0d_write%0d", t, n_w), 64'({flags(), addr_a, addr_b, data_a, data_b}),
              64'({dup(3'b110), last_a, last_b, last_d, last_d}));
          n_w++;
        end else if (n_w < 9) begin
          chk($sformatf("rand%0d_stall", t), 64'({flags(), addr_a, addr_b, data_a, data_b}),
              64'({dup(3'b010), last_a, last_b, last_d, last_d}));
        end else begin
          chk($sformatf("rand%0d_done", t), 64'(flags()), 64'(dup(3'b001)));
          finished = 1;
        end
        prev_hold = (cyc < 50 && $urandom_range(0, 2) == 0) ? 1 : 0;
        hold = prev_hold[0];
        if (finished == 0) tick();
      end
      chk($sformatf("rand%0d_finished", t), 64'(finished), 64'd1);
      hold = 1'b0;
      tick();
      chk($sformatf("rand%0d_idle", t), 64'(flags()), 64'd0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
